serial_sub16: RTL

- Bit-serial two's-complement subtractor that computes diff = a - b over WIDTH cycles, one bit per cycle, starting from bit 0 (LSB).
- Complements the datapath's parallel ripple adder; used where area matters more than latency, e.g. a multi-cycle ALU path or a compare unit.
- A start/busy/done handshake lets a controller launch an operation and wait for its result.

---
 rtl/serial_sub16_pkg.sv | 19 +
 rtl/serial_sub16_if.sv | 34 +++
 rtl/serial_sub16_cell.sv | 20 ++
 rtl/serial_sub16.sv | 113 +++++++++++
 4 files changed

// File: rtl/serial_sub16_pkg.sv
// ============================================================================
// serial_sub16_pkg : shared state encoding and default width for serial_sub16
// Revision: 1.0
// ============================================================================
`default_nettype none

package serial_sub16_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_sub16_if.sv
// ============================================================================
// serial_sub16_if : start/busy/done handshake and operand/result bus
// Revision: 1.0
// ============================================================================
`default_nettype none

interface serial_sub16_if
  import serial_sub16_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b,
    input  diff, borrow, overflow, busy, done
  );

  modport slave (
    input  start, a, b,
    output diff, borrow, overflow, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/serial_sub16_cell.sv
// ============================================================================
// serial_sub_cell : combinational 1-bit full adder reused every serial cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_sub_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

`default_nettype wire

// File: rtl/serial_sub16.sv
// ============================================================================
// serial_sub16 : bit-serial two's-complement subtractor, diff = a - b, LSB first
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_sub16
  import serial_sub16_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clock,
  input  logic           reset,
  serial_sub16_if.slave  bus
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_reg;
  logic [CW-1:0]    count;
  logic             carry;
  logic             a_msb;
  logic             b_msb;
  logic             borrow_reg;
  logic             overflow_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             b_inv;
  logic             bit_sum;
  logic             bit_carry;

  // Subtraction as a + ~b + 1: the +1 enters through the initial carry.
  assign b_inv = ~b_sh[0];

  serial_sub_cell u_cell (
    .x    (a_sh[0]),
    .y    (b_inv),
    .cin  (carry),
    .s    (bit_sum),
    .cout (bit_carry)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      a_sh         <= '0;
      b_sh         <= '0;
      diff_reg     <= '0;
      count        <= '0;
      carry        <= 1'b1;
      a_msb        <= 1'b0;
      b_msb        <= 1'b0;
      borrow_reg   <= 1'b0;
      overflow_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_sh     <= bus.a;
            b_sh     <= bus.b;
            a_msb    <= bus.a[WIDTH-1];
            b_msb    <= bus.b[WIDTH-1];
            carry    <= 1'b1;
            count    <= '0;
            diff_reg <= '0;
            busy_reg <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          diff_reg[count] <= bit_sum;
          carry           <= bit_carry;
          a_sh            <= a_sh >> 1;
          b_sh            <= b_sh >> 1;
          // Hold the counter at the last index so it never wraps.
          if (count == LAST) begin
            state <= ST_DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        ST_DONE: begin
          done_reg     <= 1'b1;
          borrow_reg   <= ~carry;
          overflow_reg <= (a_msb != b_msb) && (diff_reg[WIDTH-1] != a_msb);
          busy_reg     <= 1'b0;
          state        <= ST_IDLE;
        end
        default: begin
          busy_reg <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.diff     = diff_reg;
  assign bus.borrow   = borrow_reg;
  assign bus.overflow = overflow_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;

endmodule

`default_nettype wire
